// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: gshare BHT for direction, direct-mapped tagged BTB for target.
// Lookup is combinational on fetch_pc; training happens on the clock edge where upd_valid is high.
module branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int GHR_BITS    = 8,
    parameter int TAG_BITS    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [63:0] pred_target,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] ctr_branches,
    output logic [31:0] ctr_mispred
);
    localparam int IB = $clog2(BTB_ENTRIES);
    localparam int HB = $clog2(BHT_ENTRIES);
    localparam int TAG_LSB = IB + 2;

    logic [BTB_ENTRIES-1:0] btb_v;
    logic [BTB_ENTRIES-1:0] btb_jmp;
    logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
    logic [63:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             bht        [BHT_ENTRIES];
    logic [GHR_BITS-1:0]    ghr;

    logic [IB-1:0]       fetch_bi;
    logic [TAG_BITS-1:0] fetch_tag;
    logic [HB-1:0]       fetch_hi;
    logic [IB-1:0]       upd_bi;
    logic [TAG_BITS-1:0] upd_tag;
    logic [HB-1:0]       upd_hi;
    logic [1:0]          upd_ctr;

    // Only the index, tag and hash fields of the PCs matter; the rest is deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[63:TAG_LSB+TAG_BITS], fetch_pc[1:0],
                              upd_pc[63:TAG_LSB+TAG_BITS], upd_pc[1:0]};

    assign fetch_bi  = fetch_pc[IB+1:2];
    assign fetch_tag = fetch_pc[TAG_LSB +: TAG_BITS];
    assign fetch_hi  = fetch_pc[HB+1:2] ^ HB'(ghr);

    assign upd_bi  = upd_pc[IB+1:2];
    assign upd_tag = upd_pc[TAG_LSB +: TAG_BITS];
    assign upd_hi  = upd_pc[HB+1:2] ^ HB'(ghr);
    assign upd_ctr = bht[upd_hi];

    // Tag and target arrays are unreset; the valid bit gates them so outputs stay defined.
    assign pred_hit    = btb_v[fetch_bi] && (btb_tag[fetch_bi] == fetch_tag);
    assign pred_taken  = fetch_valid && pred_hit && (btb_jmp[fetch_bi] || bht[fetch_hi][1]);
    assign pred_target = pred_taken ? btb_target[fetch_bi] : fetch_pc + 64'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_v        <= '0;
            ghr          <= '0;
            ctr_branches <= '0;
            ctr_mispred  <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            ctr_branches <= ctr_branches + 32'd1;
            ctr_mispred  <= ctr_mispred + {31'd0, upd_mispredict};
            if (!upd_is_jump) begin
                if (upd_taken) begin
                    if (upd_ctr != 2'b11) bht[upd_hi] <= upd_ctr + 2'd1;
                end else begin
                    if (upd_ctr != 2'b00) bht[upd_hi] <= upd_ctr - 2'd1;
                end
                ghr <= {ghr[GHR_BITS-2:0], upd_taken};
            end
            // Only taken outcomes allocate; a conflicting tag simply gets overwritten.
            if (upd_taken) begin
                btb_v[upd_bi]      <= 1'b1;
                btb_jmp[upd_bi]    <= upd_is_jump;
                btb_tag[upd_bi]    <= upd_tag;
                btb_target[upd_bi] <= upd_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor; hand-computed expectations track GHR and BHT state.
module tb_branch_predictor;
    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] ctr_branches;
    logic [31:0] ctr_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        fv;
        logic [63:0] fpc;
        logic        uv;
        logic [63:0] upc;
        logic        ujmp;
        logic        utaken;
        logic [63:0] utgt;
        logic        umis;
        logic        exp_hit;
        logic        exp_taken;
        logic [63:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_jump    (upd_is_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .ctr_branches   (ctr_branches),
        .ctr_mispred    (ctr_mispred)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic fv, logic [63:0] fpc,
                                logic uv, logic [63:0] upc, logic ujmp, logic utaken,
                                logic [63:0] utgt, logic umis,
                                logic eh, logic et, logic [63:0] etgt);
        vec_t v;
        v.name = name; v.fv = fv; v.fpc = fpc;
        v.uv = uv; v.upc = upc; v.ujmp = ujmp; v.utaken = utaken; v.utgt = utgt; v.umis = umis;
        v.exp_hit = eh; v.exp_taken = et; v.exp_tgt = etgt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        fetch_valid    = v.fv;
        fetch_pc       = v.fpc;
        upd_valid      = v.uv;
        upd_pc         = v.upc;
        upd_is_jump    = v.ujmp;
        upd_taken      = v.utaken;
        upd_target     = v.utgt;
        upd_mispredict = v.umis;
        #1;
        checkOutput({v.name, ".hit"},    {63'd0, pred_hit},   {63'd0, v.exp_hit});
        checkOutput({v.name, ".taken"},  {63'd0, pred_taken}, {63'd0, v.exp_taken});
        checkOutput({v.name, ".target"}, pred_target,         v.exp_tgt);
    endtask

    task automatic idleUpdate();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        upd_taken      = 1'b0;
        upd_is_jump    = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idleUpdate();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic branchUpdate(input logic [63:0] pc, input logic mis);
        @(negedge clk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = mis;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = B;
        upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;

        // Reset and jump allocation
        vecs.push_back(mk("t1_reset",   1, B,         0, 0,         0, 0, 0,          0, 0, 0, B + 64'h4));
        vecs.push_back(mk("t2_same",    1, B + 'h10,  1, B + 'h10,  1, 1, B + 'h100,  1, 0, 0, B + 64'h14));
        vecs.push_back(mk("t2_hit",     1, B + 'h10,  0, 0,         0, 0, 0,          0, 1, 1, B + 64'h100));
        vecs.push_back(mk("t2_fv0",     0, B + 'h10,  0, 0,         0, 0, 0,          0, 1, 0, B + 64'h14));
        // Conditional branch: 01 -> 10, then GHR flushed back to zero with not-taken branches elsewhere
        vecs.push_back(mk("t3_first",   1, B + 'h20,  1, B + 'h20,  0, 1, B + 'h200,  1, 0, 0, B + 64'h24));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("t3_ghr", 1, B + 'h20,  1, B + 'h200, 0, 0, 0,          0, 1, 0, B + 64'h24));
        vecs.push_back(mk("t3_pred_t",  1, B + 'h20,  1, B + 'h20,  0, 0, 0,          1, 1, 1, B + 64'h200));
        vecs.push_back(mk("t3_nt1",     1, B + 'h20,  1, B + 'h20,  0, 0, 0,          0, 1, 0, B + 64'h24));
        vecs.push_back(mk("t3_nt2",     1, B + 'h20,  1, B + 'h20,  0, 0, 0,          0, 1, 0, B + 64'h24));
        vecs.push_back(mk("t3_sat0",    1, B + 'h20,  0, 0,         0, 0, 0,          0, 1, 0, B + 64'h24));
        // Fill GHR with ones so repeated updates of B+0x300 land on one BHT entry (index 0x3F)
        vecs.push_back(mk("t4_fill0",   1, B,         1, B + 'h304, 0, 1, B + 'h800,  0, 0, 0, B + 64'h4));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk("t4_fill", 1, B,        1, B + 'h300, 0, 1, B + 'h700,  0, 0, 0, B + 64'h4));
        vecs.push_back(mk("t4_t1",      1, B + 'h300, 1, B + 'h300, 0, 1, B + 'h700,  0, 1, 0, B + 64'h304));
        vecs.push_back(mk("t4_t2",      1, B + 'h300, 1, B + 'h300, 0, 1, B + 'h700,  0, 1, 1, B + 64'h700));
        vecs.push_back(mk("t4_t3",      1, B + 'h300, 1, B + 'h300, 0, 1, B + 'h700,  0, 1, 1, B + 64'h700));
        vecs.push_back(mk("t4_t4",      1, B + 'h300, 1, B + 'h300, 0, 1, B + 'h700,  0, 1, 1, B + 64'h700));
        vecs.push_back(mk("t4_nt",      1, B + 'h300, 1, B + 'h300, 0, 0, 0,          1, 1, 1, B + 64'h700));
        vecs.push_back(mk("t4_still",   1, B + 'h304, 0, 0,         0, 0, 0,          0, 1, 1, B + 64'h800));
        // Same-cycle lookup/update, alias eviction, and not-taken never evicting
        vecs.push_back(mk("t5_same",    1, B + 'h30,  1, B + 'h30,  1, 1, B + 'hA00,  0, 0, 0, B + 64'h34));
        vecs.push_back(mk("t5_next",    1, B + 'h30,  0, 0,         0, 0, 0,          0, 1, 1, B + 64'hA00));
        vecs.push_back(mk("t5_alias",   1, B + 'h30,  1, B + 'h130, 1, 1, B + 'hB00,  0, 1, 1, B + 64'hA00));
        vecs.push_back(mk("t5_evicted", 1, B + 'h30,  0, 0,         0, 0, 0,          0, 0, 0, B + 64'h34));
        vecs.push_back(mk("t5_ahit",    1, B + 'h130, 1, B + 'h230, 0, 0, 0,          0, 1, 1, B + 64'hB00));
        vecs.push_back(mk("t5_nt_kept", 1, B + 'h130, 0, 0,         0, 0, 0,          0, 1, 1, B + 64'hB00));

        doReset();
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Counters: reset clears BTB and counters
        doReset();
        fetch_valid = 1'b1;
        fetch_pc    = B + 'h10;
        #1;
        checkOutput("t6_rst_hit",  {63'd0, pred_hit}, 64'd0);
        checkOutput("t6_rst_tgt",  pred_target, B + 64'h14);
        checkOutput("t6_rst_br",   {32'd0, ctr_branches}, 64'd0);
        checkOutput("t6_rst_mis",  {32'd0, ctr_mispred},  64'd0);

        branchUpdate(B + 'h200, 1'b1);
        branchUpdate(B + 'h200, 1'b0);
        branchUpdate(B + 'h200, 1'b1);
        branchUpdate(B + 'h200, 1'b0);
        branchUpdate(B + 'h200, 1'b0);
        @(negedge clk);
        upd_valid      = 1'b0;
        upd_mispredict = 1'b1;
        @(negedge clk);
        idleUpdate();
        #1;
        checkOutput("t6_branches", {32'd0, ctr_branches}, 64'd5);
        checkOutput("t6_mispred",  {32'd0, ctr_mispred},  64'd2);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.ctr_branches = 32'hFFFF_FFFF;
        #1;
        release dut.ctr_branches;
        upd_valid      = 1'b1;
        upd_pc         = B + 'h200;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b1;
        @(negedge clk);
        idleUpdate();
        #1;
        checkOutput("t6_wrap_br",  {32'd0, ctr_branches}, 64'd0);
        checkOutput("t6_wrap_mis", {32'd0, ctr_mispred},  64'd3);

        // Reset wins over a simultaneous update
        @(negedge clk);
        reset          = 1'b1;
        upd_valid      = 1'b1;
        upd_pc         = B + 'h40;
        upd_is_jump    = 1'b1;
        upd_taken      = 1'b1;
        upd_target     = B + 'hC00;
        upd_mispredict = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idleUpdate();
        fetch_valid = 1'b1;
        fetch_pc    = B + 'h40;
        #1;
        checkOutput("t6_rw_br",    {32'd0, ctr_branches}, 64'd0);
        checkOutput("t6_rw_mis",   {32'd0, ctr_mispred},  64'd0);
        checkOutput("t6_rw_hit",   {63'd0, pred_hit},     64'd0);
        checkOutput("t6_rw_taken", {63'd0, pred_taken},   64'd0);
        checkOutput("t6_rw_tgt",   pred_target, B + 64'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
